// File: rtl/fpu_ss_xif_arbiter.sv
// Round-robin X-interface issue arbiter for a shared fpu_ss instance.
// Remaps (core, id) to local tags and routes results back by tag lookup.
module fpu_ss_xif_arbiter #(
    parameter int unsigned NB_CORES     = 8,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    localparam int unsigned TAG_W       = $clog2(MAX_INFLIGHT),
    localparam int unsigned CORE_W      = $clog2(NB_CORES)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NB_CORES-1:0]          core_issue_valid_i,
    output logic [NB_CORES-1:0]          core_issue_ready_o,
    input  logic [NB_CORES*32-1:0]       core_issue_instr_i,
    input  logic [NB_CORES*ID_WIDTH-1:0] core_issue_id_i,
    output logic                         core_issue_accept_o,
    output logic                         fpu_issue_valid_o,
    input  logic                         fpu_issue_ready_i,
    output logic [31:0]                  fpu_issue_instr_o,
    output logic [TAG_W-1:0]             fpu_issue_id_o,
    input  logic                         fpu_issue_accept_i,
    input  logic                         fpu_result_valid_i,
    output logic                         fpu_result_ready_o,
    input  logic [TAG_W-1:0]             fpu_result_id_i,
    input  logic [DATA_WIDTH-1:0]        fpu_result_data_i,
    output logic [NB_CORES-1:0]          core_result_valid_o,
    input  logic [NB_CORES-1:0]          core_result_ready_i,
    output logic [ID_WIDTH-1:0]          core_result_id_o,
    output logic [DATA_WIDTH-1:0]        core_result_data_o,
    output logic [TAG_W:0]               inflight_o,
    output logic                         tag_err_o
);

    logic [MAX_INFLIGHT-1:0] busy_q, busy_d;
    logic [CORE_W-1:0]       owner_q [MAX_INFLIGHT];
    logic [ID_WIDTH-1:0]     cid_q   [MAX_INFLIGHT];
    logic [CORE_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                    lock_q, lock_d;
    logic [CORE_W-1:0]       lock_grant_q, lock_grant_d;

    logic [TAG_W-1:0]  free_tag;
    logic              full;
    logic [CORE_W-1:0] rr_grant;
    logic [CORE_W-1:0] grant;
    logic              issue_valid;
    logic              issue_hs;
    logic              alloc;
    logic              res_busy;
    logic [CORE_W-1:0] res_owner;
    logic              res_free;
    logic [TAG_W:0]    busy_cnt;

    // Lowest free tag from the registered busy mask, plus occupancy count.
    always_comb begin
        free_tag = '0;
        busy_cnt = '0;
        for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_tag = TAG_W'(i);
            busy_cnt = busy_cnt + {{TAG_W{1'b0}}, busy_q[i]};
        end
        full = &busy_q;
    end

    // First valid core after rr_ptr, searching cyclically.
    always_comb begin
        rr_grant = '0;
        for (int i = int'(NB_CORES); i >= 1; i--) begin
            if (core_issue_valid_i[(int'(rr_ptr_q) + i) % int'(NB_CORES)])
                rr_grant = CORE_W'((int'(rr_ptr_q) + i) % int'(NB_CORES));
        end
    end

    // Issue path: pass the (possibly locked) grant through to fpu_ss.
    always_comb begin
        grant       = lock_q ? lock_grant_q : rr_grant;
        issue_valid = !rst_i && !full && core_issue_valid_i[grant];
        issue_hs    = issue_valid && fpu_issue_ready_i;
        alloc       = issue_hs && fpu_issue_accept_i;

        fpu_issue_valid_o   = issue_valid;
        fpu_issue_instr_o   = rst_i ? '0 : core_issue_instr_i[grant*32 +: 32];
        fpu_issue_id_o      = rst_i ? '0 : free_tag;
        core_issue_ready_o  = issue_hs ? (NB_CORES'(1) << grant) : '0;
        core_issue_accept_o = alloc;
    end

    // Result path: route by tag owner; results on free tags are dropped.
    always_comb begin
        res_busy  = busy_q[fpu_result_id_i];
        res_owner = owner_q[fpu_result_id_i];
        res_free  = !rst_i && fpu_result_valid_i && res_busy
                    && core_result_ready_i[res_owner];

        core_result_valid_o = '0;
        if (!rst_i && fpu_result_valid_i && res_busy)
            core_result_valid_o = NB_CORES'(1) << res_owner;
        fpu_result_ready_o = !rst_i && (!res_busy || core_result_ready_i[res_owner]);
        tag_err_o          = !rst_i && fpu_result_valid_i && !res_busy;
        core_result_id_o   = rst_i ? '0 : cid_q[fpu_result_id_i];
        core_result_data_o = rst_i ? '0 : fpu_result_data_i;
        inflight_o         = rst_i ? '0 : busy_cnt;
    end

    // Next-state for busy mask, round-robin pointer and grant lock.
    always_comb begin
        busy_d = busy_q;
        if (res_free) busy_d[fpu_result_id_i] = 1'b0;
        if (alloc)    busy_d[free_tag]        = 1'b1;
        rr_ptr_d     = issue_hs ? grant : rr_ptr_q;
        lock_d       = issue_valid && !fpu_issue_ready_i;
        lock_grant_d = grant;
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q       <= '0;
            rr_ptr_q     <= CORE_W'(NB_CORES - 1);
            lock_q       <= 1'b0;
            lock_grant_q <= '0;
        end else begin
            busy_q       <= busy_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_grant_q <= lock_grant_d;
        end
    end

    // Tag table payload, written on allocation only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
                owner_q[i] <= '0;
                cid_q[i]   <= '0;
            end
        end else if (alloc) begin
            owner_q[free_tag] <= grant;
            cid_q[free_tag]   <= core_issue_id_i[grant*ID_WIDTH +: ID_WIDTH];
        end
    end

endmodule

// File: tb/tb_fpu_ss_xif_arbiter.sv
// Directed self-checking bench for fpu_ss_xif_arbiter.
// Eight cores, four tags, hand-computed expectations.
module tb_fpu_ss_xif_arbiter;

    localparam int NB = 8;
    localparam int IW = 4;
    localparam int TW = 2;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NB-1:0]   c_iv;
    logic [NB-1:0]   c_ir;
    logic [NB*32-1:0] c_instr;
    logic [NB*IW-1:0] c_id;
    logic            c_acc;
    logic            f_iv;
    logic            f_ir;
    logic [31:0]     f_instr;
    logic [TW-1:0]   f_id;
    logic            f_acc;
    logic            f_rv;
    logic            f_rr;
    logic [TW-1:0]   f_rid;
    logic [DW-1:0]   f_rdata;
    logic [NB-1:0]   c_rv;
    logic [NB-1:0]   c_rr;
    logic [IW-1:0]   c_rid;
    logic [DW-1:0]   c_rdata;
    logic [TW:0]     inflight;
    logic            tag_err;

    int checks = 0;
    int errors = 0;

    fpu_ss_xif_arbiter dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .core_issue_valid_i  (c_iv),
        .core_issue_ready_o  (c_ir),
        .core_issue_instr_i  (c_instr),
        .core_issue_id_i     (c_id),
        .core_issue_accept_o (c_acc),
        .fpu_issue_valid_o   (f_iv),
        .fpu_issue_ready_i   (f_ir),
        .fpu_issue_instr_o   (f_instr),
        .fpu_issue_id_o      (f_id),
        .fpu_issue_accept_i  (f_acc),
        .fpu_result_valid_i  (f_rv),
        .fpu_result_ready_o  (f_rr),
        .fpu_result_id_i     (f_rid),
        .fpu_result_data_i   (f_rdata),
        .core_result_valid_o (c_rv),
        .core_result_ready_i (c_rr),
        .core_result_id_o    (c_rid),
        .core_result_data_o  (c_rdata),
        .inflight_o          (inflight),
        .tag_err_o           (tag_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    int g [6] = '{0, 2, 5, 0, 2, 5};

    initial begin
        rst     = 1'b1;
        c_iv    = '0;
        f_ir    = 1'b0;
        f_acc   = 1'b0;
        f_rv    = 1'b0;
        f_rid   = '0;
        f_rdata = '0;
        c_rr    = '0;
        for (int i = 0; i < NB; i++) begin
            c_instr[i*32 +: 32] = 32'hC0DE_0000 | i;
            c_id[i*IW +: IW]    = IW'(i + 1);
        end
        c_id[6*IW +: IW] = 4'hA;
        c_id[7*IW +: IW] = 4'hA;

        // Reset: outputs held at zero even with active inputs
        nxt();
        c_iv = '1; f_ir = 1'b1; f_acc = 1'b1; f_rv = 1'b1; c_rr = '1;
        f_rdata = 32'h1234_5678;
        #1;
        chk("rst_fiv", f_iv, 0);
        chk("rst_cir", c_ir, 0);
        chk("rst_frr", f_rr, 0);
        chk("rst_crv", c_rv, 0);
        chk("rst_err", tag_err, 0);
        chk("rst_inf", inflight, 0);
        chk("rst_dat", c_rdata, 0);
        nxt();
        rst = 1'b0; c_iv = '0; f_rv = 1'b0;

        // 1: round-robin over cores 0,2,5 with previous tag returned each cycle
        c_iv = 8'h25; f_ir = 1'b1; f_acc = 1'b1; c_rr = '1;
        for (int k = 0; k < 6; k++) begin
            f_rv    = (k > 0);
            f_rid   = TW'((k + 1) % 2);
            f_rdata = 32'hD000_0000 + k;
            #1;
            chk("t1_grant", c_ir, 64'(8'(1) << g[k]));
            chk("t1_tag", f_id, k % 2);
            chk("t1_acc", c_acc, 1);
            if (k > 0) begin
                chk("t1_rvalid", c_rv, 64'(8'(1) << g[k-1]));
                chk("t1_rid", c_rid, g[k-1] + 1);
                chk("t1_rdata", c_rdata, 32'hD000_0000 + k);
                chk("t1_inf", inflight, 1);
            end
            nxt();
        end
        c_iv = '0; f_rv = 1'b1; f_rid = 2'd1;
        #1;
        chk("t1_last_rv", c_rv, 8'h20);
        chk("t1_last_inf", inflight, 1);
        nxt();
        f_rv = 1'b0;
        #1;
        chk("t1_drained", inflight, 0);

        // 2: grant lock while fpu not ready, core 1 joins later
        c_iv = 8'h08; f_ir = 1'b0;
        #1;
        chk("t2_fiv", f_iv, 1);
        chk("t2_instr0", f_instr, 32'hC0DE_0003);
        chk("t2_cir0", c_ir, 0);
        nxt();
        c_iv = 8'h0A;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2_instr_lock", f_instr, 32'hC0DE_0003);
            chk("t2_cir_lock", c_ir, 0);
            nxt();
        end
        f_ir = 1'b1;
        #1;
        chk("t2_hs3", c_ir, 8'h08);
        chk("t2_acc3", c_acc, 1);
        chk("t2_tag3", f_id, 0);
        nxt();
        c_iv = 8'h02;
        #1;
        chk("t2_hs1", c_ir, 8'h02);
        chk("t2_instr1", f_instr, 32'hC0DE_0001);
        chk("t2_tag1", f_id, 1);
        nxt();

        // 3: fill the table, block, then reuse a returned tag
        c_iv = 8'h10;
        #1;
        chk("t3_tag2", f_id, 2);
        chk("t3_g4a", c_ir, 8'h10);
        nxt();
        #1;
        chk("t3_tag3", f_id, 3);
        nxt();
        #1;
        chk("t3_full_inf", inflight, 4);
        chk("t3_full_fiv", f_iv, 0);
        chk("t3_full_cir", c_ir, 0);
        f_rv = 1'b1; f_rid = 2'd2;
        #1;
        chk("t3_ret_rv", c_rv, 8'h10);
        chk("t3_ret_frr", f_rr, 1);
        chk("t3_ret_fiv", f_iv, 0);
        nxt();
        f_rv = 1'b0;
        #1;
        chk("t3_resume_fiv", f_iv, 1);
        chk("t3_resume_tag", f_id, 2);
        chk("t3_resume_inf", inflight, 3);
        nxt();
        c_iv = '0; f_rv = 1'b1;
        f_rid = 2'd0; #1; chk("t3_d0", c_rv, 8'h08); chk("t3_d0id", c_rid, 4); nxt();
        f_rid = 2'd1; #1; chk("t3_d1", c_rv, 8'h02); chk("t3_d1id", c_rid, 2); nxt();
        f_rid = 2'd2; #1; chk("t3_d2", c_rv, 8'h10); chk("t3_d2id", c_rid, 5); nxt();
        f_rid = 2'd3; #1; chk("t3_d3", c_rv, 8'h10); nxt();
        f_rv = 1'b0;
        #1;
        chk("t3_empty", inflight, 0);

        // 4: same core id from two cores maps to distinct tags
        c_iv = 8'h20; #1; chk("t4_g5", c_ir, 8'h20); chk("t4_t5", f_id, 0); nxt();
        c_iv = 8'h40; #1; chk("t4_g6", c_ir, 8'h40); chk("t4_t6", f_id, 1); nxt();
        c_iv = '0; f_rv = 1'b1; f_rid = 2'd0;
        #1; chk("t4_r5", c_rv, 8'h20); chk("t4_r5id", c_rid, 6); nxt();
        f_rv = 1'b0; c_iv = 8'h80;
        #1; chk("t4_g7", c_ir, 8'h80); chk("t4_t7", f_id, 0); nxt();
        c_iv = '0; f_rv = 1'b1; f_rid = 2'd1;
        #1; chk("t4_r6", c_rv, 8'h40); chk("t4_r6id", c_rid, 4'hA); nxt();

        // 5: owner back-pressure keeps the entry busy
        f_rid = 2'd0; c_rr = 8'h7F;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_frr_low", f_rr, 0);
            chk("t5_rv", c_rv, 8'h80);
            chk("t5_inf", inflight, 1);
            nxt();
        end
        c_rr = '1;
        #1;
        chk("t5_frr_high", f_rr, 1);
        chk("t5_rid", c_rid, 4'hA);
        nxt();
        f_rv = 1'b0;
        #1;
        chk("t5_freed", inflight, 0);

        // 6: result on a free tag, then a rejected offload
        f_rv = 1'b1; f_rid = 2'd3;
        #1;
        chk("t6_err", tag_err, 1);
        chk("t6_rv", c_rv, 0);
        chk("t6_frr", f_rr, 1);
        nxt();
        f_rv = 1'b0;
        #1;
        chk("t6_err_clr", tag_err, 0);
        c_iv = 8'h01; f_acc = 1'b0;
        #1;
        chk("t6_g0", c_ir, 8'h01);
        chk("t6_acc", c_acc, 0);
        nxt();
        c_iv = '0;
        #1;
        chk("t6_inf", inflight, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
